seq_alu: RTL and testbench

SEQ_ALU -- requirements
Module: seq_alu

---
 rtl/seq_alu.sv | 208 ++++++++++++++++++++
 tb/tb_seq_alu.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// Sequential ALU with IDLE/BUSY/DONE handshake; MUL opcode present only when ALU_MUL_EN is defined.
// Latency: 1 edge for single-cycle ops, n+1 for shift-by-n, WIDTH+1 for MUL (accept edge counts as the first).
// Backpressure: result and flags hold in DONE until out_ready; in_ready only while IDLE and out of reset.
module seq_alu #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       opcode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Result,
    output logic             Carry,
    output logic             Zero,
    output logic             Negative,
    output logic             Overflow
);

    localparam int CNTW = $clog2(WIDTH);
`ifdef ALU_MUL_EN
    localparam int ACCW = 2 * WIDTH;
    localparam logic [3:0] OP_MUL = 4'b1010;
`else
    localparam int ACCW = WIDTH;
`endif

    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_SUB   = 4'b0001;
    localparam logic [3:0] OP_AND   = 4'b0010;
    localparam logic [3:0] OP_OR    = 4'b0011;
    localparam logic [3:0] OP_XOR   = 4'b0100;
    localparam logic [3:0] OP_NOR   = 4'b0101;
    localparam logic [3:0] OP_SHL1  = 4'b0110;
    localparam logic [3:0] OP_SHR1  = 4'b0111;
    localparam logic [3:0] OP_SHL_N = 4'b1000;
    localparam logic [3:0] OP_SHR_N = 4'b1001;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             state, state_nxt;
    logic [ACCW-1:0]    acc, acc_nxt;
    logic [CNTW:0]      cnt, cnt_nxt;
    logic [3:0]         op_r, op_nxt;
`ifdef ALU_MUL_EN
    logic [WIDTH-1:0]   mcand, mcand_nxt;
    logic [WIDTH:0]     msum;
`endif
    logic               fin;
    logic [WIDTH-1:0]   res_nxt;
    logic               c_nxt, v_nxt;
    logic [WIDTH-1:0]   q_res;
    logic               q_c, q_v;
    logic [WIDTH:0]     ext;
    logic [CNTW-1:0]    n;
    logic               accept;

    assign in_ready  = (state == IDLE) && rst_n;
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;
    assign n         = B[CNTW-1:0];

    // Single-cycle results; a zero-length shift passes A through with no carry.
    always_comb begin
        ext   = '0;
        q_res = '0;
        q_c   = 1'b0;
        q_v   = 1'b0;
        case (opcode)
            OP_ADD: begin
                ext   = {1'b0, A} + {1'b0, B};
                q_res = ext[WIDTH-1:0];
                q_c   = ext[WIDTH];
                q_v   = (A[WIDTH-1] == B[WIDTH-1]) && (ext[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
                ext   = {1'b0, A} - {1'b0, B};
                q_res = ext[WIDTH-1:0];
                q_c   = ext[WIDTH];
                q_v   = (A[WIDTH-1] != B[WIDTH-1]) && (ext[WIDTH-1] != A[WIDTH-1]);
            end
            OP_AND:   q_res = A & B;
            OP_OR:    q_res = A | B;
            OP_XOR:   q_res = A ^ B;
            OP_NOR:   q_res = ~(A | B);
            OP_SHL1: begin
                q_res = {A[WIDTH-2:0], 1'b0};
                q_c   = A[WIDTH-1];
            end
            OP_SHR1: begin
                q_res = {1'b0, A[WIDTH-1:1]};
                q_c   = A[0];
            end
            OP_SHL_N, OP_SHR_N: q_res = A;
            default:  q_res = '0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        cnt_nxt   = cnt;
        op_nxt    = op_r;
`ifdef ALU_MUL_EN
        mcand_nxt = mcand;
        msum      = '0;
`endif
        fin       = 1'b0;
        res_nxt   = '0;
        c_nxt     = 1'b0;
        v_nxt     = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    op_nxt = opcode;
                    if ((opcode == OP_SHL_N || opcode == OP_SHR_N) && n != '0) begin
                        acc_nxt   = ACCW'(A);
                        cnt_nxt   = {1'b0, n};
                        state_nxt = BUSY;
                    end
`ifdef ALU_MUL_EN
                    else if (opcode == OP_MUL) begin
                        acc_nxt   = ACCW'(B);
                        mcand_nxt = A;
                        cnt_nxt   = (CNTW+1)'(WIDTH);
                        state_nxt = BUSY;
                    end
`endif
                    else begin
                        fin       = 1'b1;
                        res_nxt   = q_res;
                        c_nxt     = q_c;
                        v_nxt     = q_v;
                        state_nxt = DONE;
                    end
                end
            end
            BUSY: begin
                cnt_nxt = cnt - 1'b1;
`ifdef ALU_MUL_EN
                // Shift-add: multiplier sits in the low half and drains out as the product fills in.
                if (op_r == OP_MUL) begin
                    msum    = {1'b0, acc[ACCW-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
                    acc_nxt = {msum, acc[WIDTH-1:1]};
                    res_nxt = acc_nxt[WIDTH-1:0];
                    c_nxt   = |acc_nxt[ACCW-1:WIDTH];
                end else
`endif
                if (op_r == OP_SHL_N) begin
                    acc_nxt = ACCW'({acc[WIDTH-2:0], 1'b0});
                    res_nxt = acc_nxt[WIDTH-1:0];
                    c_nxt   = acc[WIDTH-1];
                end else begin
                    acc_nxt = ACCW'({1'b0, acc[WIDTH-1:1]});
                    res_nxt = acc_nxt[WIDTH-1:0];
                    c_nxt   = acc[0];
                end
                if (cnt == (CNTW+1)'(1)) begin
                    fin       = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc      <= '0;
            cnt      <= '0;
            op_r     <= '0;
`ifdef ALU_MUL_EN
            mcand    <= '0;
`endif
            Result   <= '0;
            Carry    <= 1'b0;
            Zero     <= 1'b0;
            Negative <= 1'b0;
            Overflow <= 1'b0;
        end else begin
            acc   <= acc_nxt;
            cnt   <= cnt_nxt;
            op_r  <= op_nxt;
`ifdef ALU_MUL_EN
            mcand <= mcand_nxt;
`endif
            if (fin) begin
                Result   <= res_nxt;
                Carry    <= c_nxt;
                Zero     <= (res_nxt == '0);
                Negative <= res_nxt[WIDTH-1];
                Overflow <= v_nxt;
            end
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Directed and randomized bench for seq_alu (WIDTH=8) against an arithmetic reference model.
module tb_seq_alu;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] A;
    logic [7:0] B;
    logic [3:0] opcode;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] Result;
    logic       Carry, Zero, Negative, Overflow;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_alu #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .opcode(opcode), .out_valid(out_valid), .out_ready(out_ready),
        .Result(Result), .Carry(Carry), .Zero(Zero), .Negative(Negative), .Overflow(Overflow)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: results from plain integer arithmetic on the operation's definition.
    function automatic void model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                                  output logic [7:0] r, output logic c, output logic v, output int lat);
        int ia = int'(a);
        int ib = int'(b);
        int sa = int'($signed(a));
        int sb = int'($signed(b));
        int n  = ib % 8;
        int t;
        r = 8'h00; c = 1'b0; v = 1'b0; lat = 1;
        case (op)
            4'd0: begin t = ia + ib; r = 8'(t); c = (t > 255); v = (sa + sb > 127) || (sa + sb < -128); end
            4'd1: begin t = ia - ib; r = 8'(t); c = (ia < ib); v = (sa - sb > 127) || (sa - sb < -128); end
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            4'd5: r = ~(a | b);
            4'd6: begin t = ia * 2; r = 8'(t); c = (t > 255); end
            4'd7: begin r = 8'(ia / 2); c = (ia % 2) == 1; end
            4'd8: begin
                r = a;
                if (n > 0) begin t = ia << n; r = 8'(t); c = ((t >> 8) % 2) == 1; lat = n + 1; end
            end
            4'd9: begin
                r = a;
                if (n > 0) begin r = 8'(ia >> n); c = ((ia >> (n - 1)) % 2) == 1; lat = n + 1; end
            end
`ifdef ALU_MUL_EN
            4'd10: begin t = ia * ib; r = 8'(t); c = (t > 255); lat = 9; end
`endif
            default: r = 8'h00;
        endcase
    endfunction

    // One transaction: accept, measure latency, check outputs, stall `hold` cycles, then release.
    task automatic run(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b, input int hold);
        logic [7:0] er;
        logic       ec, ev;
        int         el;
        int         lat;
        model(op, a, b, er, ec, ev, el);
        @(negedge clk);
        A = a; B = b; opcode = op; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0; A = 8'($urandom); B = 8'($urandom);
        lat = 1;
        while (out_valid !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check($sformatf("latency op=%0h a=%0h b=%0h", op, a, b), lat, el);
        check($sformatf("result op=%0h a=%0h b=%0h", op, a, b), Result, er);
        check($sformatf("flags CZNV op=%0h a=%0h b=%0h", op, a, b),
              {Carry, Zero, Negative, Overflow}, {ec, er == 8'h00, er[7], ev});
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            in_valid = 1'b1; opcode = 4'($urandom); A = 8'($urandom); B = 8'($urandom);
            @(posedge clk); #1;
            check("stall hold", {Result, Carry, Zero, Negative, Overflow},
                  {er, ec, er == 8'h00, er[7], ev});
            check("stall valid/ready", {out_valid, in_ready}, 2'b10);
        end
        @(negedge clk);
        out_ready = 1'b1; in_valid = 1'b1; opcode = 4'd0;
        @(posedge clk); #1;
        check("release valid/ready", {out_valid, in_ready}, 2'b01);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;
    endtask

    initial begin
        int seen;
        rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        opcode = 4'd0; A = 8'h01; B = 8'h01;
        repeat (2) @(posedge clk);
        #1;
        check("reset in_ready", in_ready, 1'b0);
        check("reset out_valid", out_valid, 1'b0);
        check("reset result/flags", {Result, Carry, Zero, Negative, Overflow}, 12'h000);
        @(negedge clk);
        rst_n = 1'b1; in_valid = 1'b0;
        #1;
        check("in_ready after release", in_ready, 1'b1);

        run(4'd0, 8'hFF, 8'h01, 0);
        run(4'd1, 8'h80, 8'h01, 0);
        run(4'd1, 8'h01, 8'h02, 0);
        run(4'd8, 8'h81, 8'h03, 0);
        run(4'd8, 8'h81, 8'h00, 0);
        run(4'd9, 8'h81, 8'h07, 1);
        run(4'd10, 8'h10, 8'h11, 0);
        run(4'd2, 8'hF0, 8'h3C, 5);
        run(4'd15, 8'h12, 8'h34, 0);

        // Reset partway through an operation must discard it.
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; opcode = 4'd10; A = 8'h10; B = 8'h11;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("mid-op reset out_valid", out_valid, 1'b0);
        check("mid-op reset result", Result, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("in_ready after mid-op reset", in_ready, 1'b1);
        seen = 0;
        repeat (15) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) seen = 1;
        end
        check("discarded op out_valid", seen, 0);
        run(4'd0, 8'h02, 8'h03, 0);

        for (int i = 0; i < 150; i++) begin
            run(4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom), int'($urandom_range(0, 2)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
